plru_nway: RTL and testbench

- Parametrised tree pseudo-LRU replacement tracker for an N-way set-associative cache; successor to the 2-way single-bit LRU.
- Holds WAYS-1 tree bits per set, updates them on hit/fill, and presents a victim way for the indexed set.
- Prefers invalid ways over the tree choice.
- Adds async reset and a multi-cycle flush sweep that clears all sets.
- Sits beside the tag/valid arrays in the cache datapath and is driven by the cache controller.

---
 rtl/plru_nway.sv | 131 +++++++++++++
 tb/tb_plru_nway.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_nway.sv
// Tree pseudo-LRU replacement tracker for an N-way set-associative cache.
// Keeps WAYS-1 heap-ordered tree bits per set, prefers invalid ways, and can sweep-clear all sets.
module plru_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WAYS-1:0]  hit_way,
    input  logic [SET_W-1:0] set,
    input  logic [WAYS-1:0]  valid,
    input  logic             flush,
    output logic             busy,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-1:0]  victim_onehot
);

    typedef enum logic {IDLE, SWEEP} state_t;

    genvar gi, gl;

    state_t           state_reg, state_next;
    logic [SET_W-1:0] cnt_reg, cnt_next;
    logic [WAYS-2:0]  tree_reg [SETS];

    logic [WAYS-2:0]  cur_bits;
    logic [WAYS-2:0]  path_mask;
    logic [WAYS-2:0]  new_bits;
    logic [WAY_W-1:0] hit_idx;
    logic [WAY_W-1:0] inv_idx;
    logic [WAY_W-1:0] tree_idx;
    logic [WAYS-1:0]  tree_onehot;
    logic             hit_any;
    logic             all_valid;
    logic             do_load;
    logic             sweep_clear;

    assign cur_bits  = tree_reg[set];
    assign hit_any   = |hit_way;
    assign all_valid = &valid;

    // Lowest-index priority for both the accessed way and the first invalid way.
    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = WAY_W'(i);
            if (!valid[i])  inv_idx = WAY_W'(i);
        end
    end

    // Per node: is it on the path to hit_idx, and which way must it point to avoid hit_idx.
    generate
        for (gi = 0; gi < WAYS - 1; gi++) begin : g_node
            localparam int LVL = $clog2(gi + 2) - 1;
            localparam int POS = gi + 1 - (1 << LVL);
            assign path_mask[gi] = ((32'(hit_idx) >> (WAY_W - LVL)) == POS);
            assign new_bits[gi]  = ~hit_idx[WAY_W-1-LVL];
        end
    endgenerate

    // A leaf is the tree victim when every node on its path points towards it.
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_leaf
            logic [WAY_W-1:0] step_ok;
            for (gl = 0; gl < WAY_W; gl++) begin : g_lvl
                localparam int NODE = (1 << gl) - 1 + (gi >> (WAY_W - gl));
                localparam bit DIR  = ((gi >> (WAY_W - 1 - gl)) & 1) != 0;
                assign step_ok[gl] = (cur_bits[NODE] == DIR);
            end
            assign tree_onehot[gi] = &step_ok;
        end
    endgenerate

    always_comb begin
        tree_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (tree_onehot[i]) tree_idx = tree_idx | WAY_W'(i);
        end
    end

    assign victim_way    = all_valid ? tree_idx : inv_idx;
    assign victim_onehot = WAYS'(1) << victim_way;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == SET_W'(SETS - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg == SWEEP);
    assign sweep_clear = (state_reg == SWEEP);
    assign do_load     = load && hit_any && (state_reg == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Loads are blocked during a sweep, so the two write sources never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) tree_reg[i] <= '0;
        end else if (sweep_clear) begin
            tree_reg[cnt_reg] <= '0;
        end else if (do_load) begin
            tree_reg[set] <= (cur_bits & ~path_mask) | (new_bits & path_mask);
        end
    end

endmodule

// File: tb/tb_plru_nway.sv
// Directed bench for plru_nway at 4, 2 and 8 ways; expectations go through a scoreboard queue.
module tb_plru_nway;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       load4 = 1'b0;
    logic [3:0] hit4 = '0;
    logic [3:0] set4 = '0;
    logic [3:0] valid4 = 4'b1111;
    logic       flush4 = 1'b0;
    logic       busy4;
    logic [1:0] vway4;
    logic [3:0] voh4;

    logic       load2 = 1'b0;
    logic [1:0] hit2 = '0;
    logic [1:0] valid2 = 2'b11;
    logic       busy2;
    logic [0:0] vway2;
    logic [1:0] voh2;

    logic       load8 = 1'b0;
    logic [7:0] hit8 = '0;
    logic [7:0] valid8 = 8'hFF;
    logic       busy8;
    logic [2:0] vway8;
    logic [7:0] voh8;

    logic       flush_off = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    plru_nway #(.WAYS(4), .SETS(16)) dut (
        .clk(clk), .rst(rst), .load(load4), .hit_way(hit4), .set(set4), .valid(valid4),
        .flush(flush4), .busy(busy4), .victim_way(vway4), .victim_onehot(voh4));

    plru_nway #(.WAYS(2), .SETS(16)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .hit_way(hit2), .set(set4), .valid(valid2),
        .flush(flush_off), .busy(busy2), .victim_way(vway2), .victim_onehot(voh2));

    plru_nway #(.WAYS(8), .SETS(16)) dut8 (
        .clk(clk), .rst(rst), .load(load8), .hit_way(hit8), .set(set4), .valid(valid8),
        .flush(flush_off), .busy(busy8), .victim_way(vway8), .victim_onehot(voh8));

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {30'b0, vway4};
            1:       return {31'b0, busy4};
            2:       return {28'b0, voh4};
            3:       return {31'b0, vway2};
            4:       return {29'b0, vway8};
            5:       return {24'b0, voh8};
            default: return {30'b0, voh2};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = (e.sel < 0) ? 32'(-e.sel - 100) : observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic load_4(input logic [3:0] s, input logic [3:0] h);
        @(negedge clk);
        set4 = s; hit4 = h; load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0; hit4 = '0;
    endtask

    // Pulses flush, then counts busy cycles; optionally re-flushes / loads mid-sweep.
    task automatic run_flush(input int reflush_at, input int load_at, output int n);
        @(negedge clk);
        flush4 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && busy4 === 1'b1; k++) begin
            n++;
            flush4 = (k == reflush_at);
            if (k == load_at) begin
                set4 = 4'd3; hit4 = 4'b0001; load4 = 1'b1;
            end else begin
                load4 = 1'b0; hit4 = '0;
            end
            @(negedge clk);
        end
        flush4 = 1'b0; load4 = 1'b0; hit4 = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state: every set points to way 0.
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            set4 = 4'(s);
            expect_val($sformatf("reset_victim_set%0d", s), 0, 0);
            if (s == 0) expect_val("reset_busy", 1, 0);
            drain();
        end

        // Set 5 update sequence.
        load_4(4'd5, 4'b0001);
        expect_val("set5_hit0_victim", 0, 2);
        expect_val("set5_hit0_onehot", 2, 4'b0100);
        drain();
        load_4(4'd5, 4'b0100);
        expect_val("set5_hit2_victim", 0, 1);
        drain();
        load_4(4'd5, 4'b0010);
        expect_val("set5_hit1_victim", 0, 3);
        expect_val("set5_hit1_onehot", 2, 4'b1000);
        drain();
        set4 = 4'd6;
        expect_val("set6_untouched", 0, 0);
        drain();

        // Invalid-way preference.
        set4 = 4'd5; valid4 = 4'b1011;
        expect_val("invalid_way2", 0, 2);
        drain();
        valid4 = 4'b0000;
        expect_val("all_invalid", 0, 0);
        drain();
        valid4 = 4'b1111;

        // Multi-hot hit_way uses lowest set bit.
        load_4(4'd5, 4'b1000);
        expect_val("set5_hit3_victim", 0, 0);
        drain();
        load_4(4'd5, 4'b0110);
        expect_val("multihot_as_way1", 0, 2);
        drain();
        load_4(4'd5, 4'b0000);
        expect_val("zero_hit_no_update", 0, 2);
        drain();

        // Flush sweep with ignored load and ignored re-flush.
        load_4(4'd3, 4'b0001);
        load_4(4'd15, 4'b0001);
        set4 = 4'd15;
        expect_val("set15_dirty", 0, 2);
        drain();
        run_flush(5, 8, n);
        expect_val("flush_busy_cycles", -(n + 100), 16);
        expect_val("flush_busy_low", 1, 0);
        drain();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            set4 = 4'(s);
            expect_val($sformatf("flushed_victim_set%0d", s), 0, 0);
            drain();
        end

        // Async reset in the middle of a sweep.
        load_4(4'd12, 4'b0001);
        set4 = 4'd12;
        expect_val("set12_dirty", 0, 2);
        drain();
        @(negedge clk);
        flush4 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0;
        repeat (7) @(negedge clk);
        expect_val("mid_sweep_busy", 1, 1);
        expect_val("mid_sweep_set12_dirty", 0, 2);
        drain();
        #2 rst = 1'b1;
        expect_val("async_rst_busy", 1, 0);
        expect_val("async_rst_set12", 0, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        run_flush(-1, -1, n);
        expect_val("reflush_busy_cycles", -(n + 100), 16);
        drain();

        // Two-way instance matches the legacy single-bit LRU.
        @(negedge clk);
        set4 = 4'd2; hit2 = 2'b01; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        expect_val("w2_hit0_victim", 3, 1);
        expect_val("w2_hit0_onehot", 6, 2'b10);
        drain();
        @(negedge clk);
        hit2 = 2'b10; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        expect_val("w2_hit1_victim", 3, 0);
        drain();

        // Eight-way: fill ways 0..6; way 7 still invalid, then tree walk once valid.
        valid8 = 8'h00;
        for (int w = 0; w < 7; w++) begin
            @(negedge clk);
            set4 = 4'd9; hit8 = 8'(1 << w); load8 = 1'b1;
            @(negedge clk);
            load8 = 1'b0;
            valid8[w] = 1'b1;
        end
        expect_val("w8_fill_victim7", 4, 7);
        expect_val("w8_fill_onehot", 5, 8'h80);
        drain();
        valid8 = 8'hFF;
        expect_val("w8_tree_victim", 4, 0);
        drain();
        @(negedge clk);
        hit8 = 8'h01; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        expect_val("w8_after_hit0", 4, 4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
